// File: rtl/pid_cfg_seq.sv
// Replays a software-loaded table of (address, data) writes onto a single-beat bus master
// port so the PID coefficient bank can be reprogrammed as one atomic sequence.
module pid_cfg_seq #(
  parameter int unsigned N   = 8,
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32,
  parameter int unsigned TMO = 255,
  localparam int unsigned IW = $clog2(N),
  localparam int unsigned LW = IW + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_idx,
  input  logic [AW-1:0] cfg_addr,
  input  logic [DW-1:0] cfg_data,
  input  logic [LW-1:0] cfg_len,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [IW-1:0] err_idx,
  output logic          m_wen,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_ack,
  input  logic          m_err
);

  localparam int unsigned TW = 16;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]    r_state,   w_state_nxt;
  logic [IW-1:0] r_idx,     w_idx_nxt;
  logic [LW-1:0] r_len,     w_len_nxt;
  logic [TW-1:0] r_timer,   w_timer_nxt;
  logic          r_done,    w_done_nxt;
  logic          r_error,   w_error_nxt;
  logic [IW-1:0] r_err_idx, w_err_idx_nxt;
  logic [AW-1:0] r_addr,    w_addr_nxt;
  logic [DW-1:0] r_wdata,   w_wdata_nxt;
  logic          r_busy;
  logic          r_wen;

  logic [AW-1:0] r_tab_addr [N];
  logic [DW-1:0] r_tab_data [N];

  logic [LW-1:0] w_len_clamp;
  logic          w_last;

  assign w_len_clamp = (cfg_len > LW'(N)) ? LW'(N) : cfg_len;
  assign w_last      = ({1'b0, r_idx} == (r_len - LW'(1)));

  // Table storage has no reset; software always loads it before a run.
  always_ff @(posedge clk) begin
    if (cfg_we && !r_busy) begin
      r_tab_addr[cfg_idx] <= cfg_addr;
      r_tab_data[cfg_idx] <= cfg_data;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_len_nxt     = r_len;
    w_timer_nxt   = r_timer;
    w_done_nxt    = 1'b0;
    w_error_nxt   = r_error;
    w_err_idx_nxt = r_err_idx;
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_error_nxt = 1'b0;
          if (cfg_len == LW'(0)) begin
            w_done_nxt = 1'b1;
          end else begin
            w_len_nxt   = w_len_clamp;
            w_idx_nxt   = IW'(0);
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        w_timer_nxt = TW'(0);
        w_state_nxt = abort ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        w_timer_nxt = r_timer + TW'(1);
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (m_err) begin
          w_state_nxt   = S_IDLE;
          w_error_nxt   = 1'b1;
          w_err_idx_nxt = r_idx;
        end else if (m_ack && w_last) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else if (m_ack) begin
          w_idx_nxt   = r_idx + IW'(1);
          w_state_nxt = S_ISSUE;
        end else if (r_timer == TW'(TMO - 1)) begin
          w_state_nxt   = S_IDLE;
          w_error_nxt   = 1'b1;
          w_err_idx_nxt = r_idx;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Address/data are captured on entry to ISSUE and held until the next one.
    if (w_state_nxt == S_ISSUE) begin
      w_addr_nxt  = r_tab_addr[w_idx_nxt];
      w_wdata_nxt = r_tab_data[w_idx_nxt];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_len     <= '0;
      r_timer   <= '0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_err_idx <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_busy    <= 1'b0;
      r_wen     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_len     <= w_len_nxt;
      r_timer   <= w_timer_nxt;
      r_done    <= w_done_nxt;
      r_error   <= w_error_nxt;
      r_err_idx <= w_err_idx_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_wen     <= (w_state_nxt == S_ISSUE);
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign error   = r_error;
  assign err_idx = r_err_idx;
  assign m_wen   = r_wen;
  assign m_addr  = r_addr;
  assign m_wdata = r_wdata;

endmodule

// File: tb/tb_pid_cfg_seq.sv
// Bench for pid_cfg_seq: a configurable bus slave plus a table/timing model derived from
// the sequencer's externally visible rules.
module tb_pid_cfg_seq;

  localparam int unsigned N   = 8;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 8;
  localparam int unsigned IW  = 3;
  localparam int unsigned LW  = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_data;
  logic [LW-1:0] cfg_len;
  logic          start;
  logic          abort;
  logic          busy, done, error, m_wen;
  logic [IW-1:0] err_idx;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_ack = 1'b0;
  logic          m_err = 1'b0;

  always #5 clk = ~clk;

  pid_cfg_seq #(.N(N), .AW(AW), .DW(DW), .TMO(TMO)) dut (
    .clk(clk), .rstn(rstn), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_len(cfg_len), .start(start), .abort(abort), .busy(busy),
    .done(done), .error(error), .err_idx(err_idx), .m_wen(m_wen), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_ack(m_ack), .m_err(m_err)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Reference table contents, mirrored on every accepted cfg write.
  logic [AW-1:0] mt_a [N];
  logic [DW-1:0] mt_d [N];

  // Slave configuration (written by tasks) and slave/monitor state (owned by the always block).
  int run_id = 0, seen_id = 0;
  int s_delay = 1, s_err_at = -1;
  bit s_noack = 1'b0, s_err_ack = 1'b1;
  int s_cnt = 0, s_wnum = 0;
  int cyc = 0;
  int w_n = 0, d_n = 0, d_cyc = 0;
  int w_cyc [16];
  logic [AW-1:0] w_a [16];
  logic [DW-1:0] w_d [16];
  int t0 = 0, idle_rel = 0;

  // Slave answers each write after s_delay cycles; logs writes and done pulses.
  always @(negedge clk) begin
    cyc++;
    if (run_id != seen_id) begin
      seen_id = run_id; s_cnt = 0; s_wnum = 0; w_n = 0; d_n = 0; d_cyc = 0;
    end
    m_ack = 1'b0;
    m_err = 1'b0;
    if (s_cnt > 0) begin
      s_cnt--;
      if (s_cnt == 0) begin
        if (s_wnum - 1 == s_err_at) begin
          m_err = 1'b1;
          m_ack = s_err_ack;
        end else begin
          m_ack = 1'b1;
        end
      end
    end
    if (m_wen === 1'b1) begin
      if (w_n < 16) begin
        w_cyc[w_n] = cyc; w_a[w_n] = m_addr; w_d[w_n] = m_wdata;
      end
      w_n++;
      s_wnum++;
      if (!s_noack) s_cnt = s_delay;
    end
    if (done === 1'b1) begin
      d_n++;
      d_cyc = cyc;
    end
  end

  task automatic load_table();
    for (int i = 0; i < int'(N); i++) begin
      @(negedge clk);
      cfg_we = 1'b1; cfg_idx = IW'(i); cfg_addr = $urandom; cfg_data = $urandom;
      mt_a[i] = cfg_addr; mt_d[i] = cfg_data;
    end
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic arm_slave(input int d, input int ea, input bit na, input bit eack);
    @(posedge clk); #1;
    s_delay = d; s_err_at = ea; s_noack = na; s_err_ack = eack;
    run_id++;
  endtask

  task automatic fire_start(input int len_req);
    cfg_len = LW'(len_req);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc;
  endtask

  // Starts a run and waits (bounded) for busy to fall; optional abort and busy-time pokes.
  task automatic do_run(input int len_req, input int d, input int ea, input bit na,
                        input bit eack, input int abort_rel, input bit poke);
    int rel;
    arm_slave(d, ea, na, eack);
    fire_start(len_req);
    idle_rel = -1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk); #1;
      rel = cyc - t0;
      abort = (rel == abort_rel);
      if (poke) begin
        cfg_we = (rel == 2);
        start  = (rel == 2);
        if (rel == 2) begin
          cfg_idx = IW'($urandom); cfg_addr = $urandom; cfg_data = $urandom; cfg_len = LW'(1);
        end
      end
      if (busy == 1'b0) begin
        idle_rel = rel;
        abort = 1'b0; cfg_we = 1'b0; start = 1'b0;
        break;
      end
    end
    if (idle_rel < 0) begin
      n_chk++;
      $display("FAIL run_timeout: busy still %0b after 2000 cycles, required 0", busy);
    end
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if ({busy, done, error, err_idx, m_wen, m_addr, m_wdata} !== '0)
      $display("FAIL reset_outputs: got busy=%0b done=%0b err=%0b eidx=%0d wen=%0b a=%0h d=%0h, required all 0",
               busy, done, error, err_idx, m_wen, m_addr, m_wdata);
    else n_pass++;
    rstn = 1'b1;
    load_table();
  endtask

  task automatic test_basic();
    do_run(4, 1, -1, 1'b0, 1'b1, 0, 1'b0);
    n_chk++;
    if (w_n !== 4) $display("FAIL basic_count: got %0d writes, required 4", w_n); else n_pass++;
    for (int k = 0; k < 4 && k < w_n; k++) begin
      n_chk++;
      if (w_cyc[k] - t0 !== 1 + 2 * k)
        $display("FAIL basic_wen_time[%0d]: got t%0d, required t%0d", k, w_cyc[k] - t0, 1 + 2 * k);
      else n_pass++;
      n_chk++;
      if (w_a[k] !== mt_a[k] || w_d[k] !== mt_d[k])
        $display("FAIL basic_payload[%0d]: got %0h/%0h, required %0h/%0h", k, w_a[k], w_d[k], mt_a[k], mt_d[k]);
      else n_pass++;
    end
    n_chk++;
    if (d_n !== 1 || d_cyc - t0 !== 9)
      $display("FAIL basic_done: got %0d pulses last at t%0d, required 1 at t9", d_n, d_cyc - t0);
    else n_pass++;
    n_chk++;
    if (error !== 1'b0) $display("FAIL basic_error: got %0b, required 0", error); else n_pass++;
  endtask

  task automatic test_err();
    do_run(3, 1, 1, 1'b0, 1'b1, 0, 1'b0);
    n_chk++;
    if (w_n !== 2) $display("FAIL err_count: got %0d writes, required 2", w_n); else n_pass++;
    n_chk++;
    if (error !== 1'b1 || err_idx !== 3'd1)
      $display("FAIL err_flag: got error=%0b idx=%0d, required 1/1", error, err_idx);
    else n_pass++;
    n_chk++;
    if (d_n !== 0) $display("FAIL err_done: got %0d pulses, required 0", d_n); else n_pass++;
    do_run(2, 1, -1, 1'b0, 1'b1, 0, 1'b0);
    n_chk++;
    if (error !== 1'b0 || d_n !== 1)
      $display("FAIL err_clear: got error=%0b done=%0d, required 0/1", error, d_n);
    else n_pass++;
  endtask

  task automatic test_timeout();
    do_run(4, 1, -1, 1'b1, 1'b1, 0, 1'b0);
    n_chk++;
    if (w_n !== 1) $display("FAIL tmo_count: got %0d writes, required 1", w_n); else n_pass++;
    n_chk++;
    if (idle_rel !== int'(TMO) + 2)
      $display("FAIL tmo_time: got idle at t%0d, required t%0d", idle_rel, TMO + 2);
    else n_pass++;
    n_chk++;
    if (error !== 1'b1 || err_idx !== 3'd0 || busy !== 1'b0 || d_n !== 0)
      $display("FAIL tmo_flags: got error=%0b idx=%0d busy=%0b done=%0d, required 1/0/0/0",
               error, err_idx, busy, d_n);
    else n_pass++;
  endtask

  task automatic test_abort();
    // Delay 2: entry 2 issues at t7, abort in its first WAIT (t8), ack would land at t9.
    do_run(5, 2, -1, 1'b0, 1'b1, 8, 1'b0);
    n_chk++;
    if (w_n !== 3) $display("FAIL abort_count: got %0d writes, required 3", w_n); else n_pass++;
    n_chk++;
    if (d_n !== 0 || busy !== 1'b0 || error !== 1'b0)
      $display("FAIL abort_flags: got done=%0d busy=%0b error=%0b, required 0/0/0", d_n, busy, error);
    else n_pass++;
    n_chk++;
    if (idle_rel !== 9) $display("FAIL abort_time: got idle at t%0d, required t9", idle_rel); else n_pass++;
  endtask

  task automatic test_len0_busy();
    do_run(0, 1, -1, 1'b0, 1'b1, 0, 1'b0);
    n_chk++;
    if (w_n !== 0 || d_n !== 1 || d_cyc - t0 !== 1)
      $display("FAIL len0: got %0d writes, %0d done at t%0d, required 0 writes, 1 done at t1",
               w_n, d_n, d_cyc - t0);
    else n_pass++;
    do_run(6, 1, -1, 1'b0, 1'b1, 0, 1'b1);
    n_chk++;
    if (w_n !== 6 || d_n !== 1)
      $display("FAIL busy_poke_run: got %0d writes %0d done, required 6/1", w_n, d_n);
    else n_pass++;
    do_run(8, 1, -1, 1'b0, 1'b1, 0, 1'b0);
    n_chk++;
    if (w_n !== 8) $display("FAIL readback_count: got %0d writes, required 8", w_n); else n_pass++;
    for (int k = 0; k < 8 && k < w_n; k++) begin
      n_chk++;
      if (w_a[k] !== mt_a[k] || w_d[k] !== mt_d[k])
        $display("FAIL readback[%0d]: got %0h/%0h, required %0h/%0h", k, w_a[k], w_d[k], mt_a[k], mt_d[k]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midrun();
    arm_slave(3, -1, 1'b0, 1'b1);
    fire_start(4);
    repeat (6) @(negedge clk);
    #1;
    n_chk++;
    if (busy !== 1'b1 || m_addr !== mt_a[1])
      $display("FAIL midrun_pre: got busy=%0b addr=%0h, required 1/%0h", busy, m_addr, mt_a[1]);
    else n_pass++;
    rstn = 1'b0;
    #1;
    n_chk++;
    if ({busy, done, error, err_idx, m_wen, m_addr, m_wdata} !== '0)
      $display("FAIL midrun_reset: got busy=%0b wen=%0b a=%0h d=%0h, required all 0",
               busy, m_wen, m_addr, m_wdata);
    else n_pass++;
    repeat (3) @(negedge clk);
    #1;
    rstn = 1'b1;
    do_run(3, 1, -1, 1'b0, 1'b1, 0, 1'b0);
    n_chk++;
    if (w_n !== 3 || w_a[0] !== mt_a[0] || d_n !== 1)
      $display("FAIL midrun_restart: got %0d writes first addr %0h done=%0d, required 3/%0h/1",
               w_n, w_a[0], d_n, mt_a[0]);
    else n_pass++;
  endtask

  task automatic test_random();
    int len_req, d, ea, lim, nw;
    bit eack, fail;
    for (int it = 0; it < 10; it++) begin
      if ($urandom_range(0, 1) == 1) load_table();
      len_req = int'($urandom_range(1, 15));
      d       = int'($urandom_range(1, 4));
      ea      = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
      eack    = 1'($urandom_range(0, 1));
      do_run(len_req, d, ea, 1'b0, eack, 0, 1'b0);
      lim  = (len_req > int'(N)) ? int'(N) : len_req;
      fail = (ea >= 0) && (ea < lim);
      nw   = fail ? ea + 1 : lim;
      n_chk++;
      if (w_n !== nw) $display("FAIL rnd%0d_count: got %0d writes, required %0d", it, w_n, nw);
      else n_pass++;
      for (int k = 0; k < nw && k < w_n; k++) begin
        n_chk++;
        if (w_cyc[k] - t0 !== 1 + k * (d + 1) || w_a[k] !== mt_a[k] || w_d[k] !== mt_d[k])
          $display("FAIL rnd%0d_write[%0d]: got t%0d %0h/%0h, required t%0d %0h/%0h", it, k,
                   w_cyc[k] - t0, w_a[k], w_d[k], 1 + k * (d + 1), mt_a[k], mt_d[k]);
        else n_pass++;
      end
      n_chk++;
      if (idle_rel !== nw * (d + 1) + 1)
        $display("FAIL rnd%0d_idle: got t%0d, required t%0d", it, idle_rel, nw * (d + 1) + 1);
      else n_pass++;
      n_chk++;
      if (error !== fail || d_n !== (fail ? 0 : 1) || (fail && err_idx !== IW'(ea)))
        $display("FAIL rnd%0d_status: got error=%0b idx=%0d done=%0d, required %0b/%0d/%0d", it,
                 error, err_idx, d_n, fail, ea, fail ? 0 : 1);
      else n_pass++;
    end
  endtask

  initial begin
    rstn = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0;
    cfg_len = '0; start = 1'b0; abort = 1'b0;
    test_reset();
    test_basic();
    test_err();
    test_timeout();
    test_abort();
    test_len0_busy();
    test_reset_midrun();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
